channel_error_injector: RTL and testbench

CHANNEL_ERROR_INJECTOR -- requirements
Module: channel_error_injector

---
 rtl/channel_error_injector.sv | 79 +++++++
 tb/tb_channel_error_injector.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/channel_error_injector.sv
// channel_error_injector: one-stage output-register pipeline that flips at most one bit per beat under a per-packet error budget
// Ports: clk/reset (async, active-high); in_valid/in_ready/in_sop/in_eop/in_data upstream beat;
//   err_en/err_count injection control; out_valid/out_ready/out_sop/out_eop/out_data/out_err_mask downstream beat;
//   errs_last errors in last completed packet; proto_err sticky framing violation.
module channel_error_injector #(
  parameter int unsigned DATA_W = 8,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic [DATA_W-1:0] in_data,
  input  logic              err_en,
  input  logic [2:0]        err_count,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sop,
  output logic              out_eop,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] out_err_mask,
  output logic [3:0]        errs_last,
  output logic              proto_err
);
  typedef enum logic {IDLE, IN_PKT} state_t;
  state_t state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [2:0] bud_q, bud_d, bud_eff;
  logic [3:0] cnt_q, cnt_d;
  logic in_xfer, orphan, violation, inj;
  logic [DATA_W-1:0] mask;
  assign in_ready = !out_valid || out_ready;
  assign in_xfer = in_valid && in_ready;
  always_comb begin
    orphan = state_q == IDLE && !in_sop;
    violation = orphan || (state_q == IN_PKT && in_sop);
    // Beats outside a packet get no budget, so they always pass through clean.
    bud_eff = in_sop ? err_count : orphan ? 3'd0 : bud_q;
    inj = err_en && bud_eff != 3'd0 && lfsr_q[0];
    mask = inj ? DATA_W'(1) << lfsr_q[3:1] : '0;
    lfsr_d = in_xfer ? {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000) : lfsr_q;
    bud_d = in_xfer ? bud_eff - 3'(inj) : bud_q;
    cnt_d = !in_xfer ? cnt_q : in_sop ? 4'(inj) : orphan ? 4'd0 : cnt_q + 4'(inj);
    state_d = !in_xfer ? state_q : in_sop ? (in_eop ? IDLE : IN_PKT) : in_eop ? IDLE : state_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      lfsr_q <= SEED;
      bud_q <= '0;
      cnt_q <= '0;
      out_valid <= 1'b0;
      out_sop <= 1'b0;
      out_eop <= 1'b0;
      out_data <= '0;
      out_err_mask <= '0;
      errs_last <= '0;
      proto_err <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q <= lfsr_d;
      bud_q <= bud_d;
      cnt_q <= cnt_d;
      if (in_xfer) begin
        out_valid <= 1'b1;
        out_sop <= in_sop;
        out_eop <= in_eop;
        out_data <= in_data ^ mask;
        out_err_mask <= mask;
        if (in_eop) errs_last <= cnt_d;
        if (violation) proto_err <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_channel_error_injector.sv
// tb_channel_error_injector: directed table, corner sequences and random traffic against a packet-level reference model
module tb_channel_error_injector;
  logic clk = 1'b0, reset = 1'b1;
  logic in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0, err_en = 1'b0, out_ready = 1'b1;
  logic [7:0] in_data = '0;
  logic [2:0] err_count = '0;
  logic in_ready, out_valid, out_sop, out_eop, proto_err;
  logic [7:0] out_data, out_err_mask;
  logic [3:0] errs_last;
  int n_chk = 0, n_fail = 0;
  // reference model: packet view of the stream plus expected output register
  logic [15:0] m_lfsr;
  bit m_inpkt, m_proto, m_ov, m_os, m_oe;
  int m_left, m_cnt, m_errs;
  logic [7:0] m_od, m_om;
  typedef struct {
    logic s, e, en;
    logic [7:0] d;
    logic [2:0] c;
    logic [7:0] x_data, x_mask;
    logic [3:0] x_errs;
    logic x_proto;
  } vec_t;
  vec_t vec [8];
  channel_error_injector dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop),
    .in_eop(in_eop), .in_data(in_data), .err_en(err_en), .err_count(err_count),
    .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop),
    .out_data(out_data), .out_err_mask(out_err_mask), .errs_last(errs_last), .proto_err(proto_err)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction
  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_lfsr = 16'hACE1; m_inpkt = 0; m_proto = 0; m_ov = 0; m_os = 0; m_oe = 0;
    m_left = 0; m_cnt = 0; m_errs = 0; m_od = '0; m_om = '0;
  endtask
  task automatic model_accept(input logic s, e, input logic [7:0] d, input logic en, input logic [2:0] c);
    int budget, fl;
    budget = s ? int'(c) : (m_inpkt ? m_left : 0);
    if (s == m_inpkt) m_proto = 1;
    fl = (en && budget > 0 && m_lfsr[0]) ? 1 : 0;
    m_om = fl ? 8'(1 << m_lfsr[3:1]) : 8'h00;
    m_left = budget - fl;
    m_cnt = s ? fl : (m_inpkt ? m_cnt + fl : 0);
    if (e) m_errs = m_cnt;
    m_inpkt = s ? !e : (m_inpkt && !e);
    m_od = d ^ m_om; m_os = s; m_oe = e; m_ov = 1;
    m_lfsr = lfsr_next(m_lfsr);
  endtask
  // one clock: drive at negedge, check in_ready, pass the posedge, compare at next negedge
  task automatic cycle(input logic v, s, e, input logic [7:0] d, input logic en, input logic [2:0] c, input logic r);
    in_valid = v; in_sop = s; in_eop = e; in_data = d; err_en = en; err_count = c; out_ready = r;
    #1;
    chk("in_ready", in_ready, (!m_ov || r));
    if (v && (!m_ov || r)) model_accept(s, e, d, en, c);
    else if (r) m_ov = 0;
    @(negedge clk);
    chk("out_valid", out_valid, m_ov);
    if (m_ov) begin
      chk("out_sop", out_sop, m_os);
      chk("out_eop", out_eop, m_oe);
      chk("out_data", out_data, m_od);
      chk("out_err_mask", out_err_mask, m_om);
    end
    chk("errs_last", errs_last, 4'(m_errs));
    chk("proto_err", proto_err, m_proto);
    chk("lfsr", dut.lfsr_q, m_lfsr);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst out_valid", out_valid, 0);
    chk("rst proto_err", proto_err, 0);
    chk("rst errs_last", errs_last, 0);
    chk("rst out_data", out_data, 0);
    chk("rst lfsr", dut.lfsr_q, 16'hACE1);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask
  initial begin
    int pop;
    model_reset();
    vec[0] = '{1, 1, 1, 8'h00, 3'd1, 8'h01, 8'h01, 4'd1, 0};
    vec[1] = '{1, 0, 0, 8'hA5, 3'd5, 8'hA5, 8'h00, 4'd1, 0};
    vec[2] = '{0, 0, 0, 8'hA5, 3'd5, 8'hA5, 8'h00, 4'd1, 0};
    vec[3] = '{0, 0, 0, 8'hA5, 3'd5, 8'hA5, 8'h00, 4'd1, 0};
    vec[4] = '{0, 1, 0, 8'hA5, 3'd5, 8'hA5, 8'h00, 4'd0, 0};
    vec[5] = '{0, 0, 1, 8'h3C, 3'd7, 8'h3C, 8'h00, 4'd0, 1};
    vec[6] = '{1, 0, 1, 8'h00, 3'd7, 8'h02, 8'h02, 4'd0, 1};
    vec[7] = '{0, 1, 1, 8'hFF, 3'd0, 8'hEF, 8'h10, 4'd2, 1};
    @(negedge clk);
    do_reset();
    chk("in_ready after reset", in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      cycle(1, vec[i].s, vec[i].e, vec[i].d, vec[i].en, vec[i].c, 1);
      chk($sformatf("vec%0d data", i), out_data, vec[i].x_data);
      chk($sformatf("vec%0d mask", i), out_err_mask, vec[i].x_mask);
      chk($sformatf("vec%0d errs_last", i), errs_last, vec[i].x_errs);
      chk($sformatf("vec%0d proto", i), proto_err, vec[i].x_proto);
      if (i == 0) chk("lfsr after first beat", dut.lfsr_q, 16'hE270);
      if (i == 4) chk("lfsr after 4 clean beats", dut.lfsr_q, 16'h0E27);
    end
    // backpressure: held beat stays stable, the waiting beat is taken exactly once
    cycle(0, 0, 0, 8'h00, 0, 0, 1);
    cycle(1, 1, 1, 8'h11, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 1, 1, 8'h22, 0, 0, 0);
      chk("stall in_ready", in_ready, 0);
      chk("stall data", out_data, 8'h11);
    end
    cycle(1, 1, 1, 8'h22, 0, 0, 1);
    chk("release data", out_data, 8'h22);
    cycle(0, 0, 0, 8'h00, 0, 0, 1);
    chk("consumed once", out_valid, 0);
    // zero budget over a long packet, then full budget
    for (int i = 0; i < 16; i++) cycle(1, i == 0, i == 15, 8'($urandom), 1, 0, 1);
    chk("zero budget errs", errs_last, 0);
    pop = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(1, i == 0, i == 15, 8'($urandom), 1, 7, 1);
      pop += $countones(out_err_mask);
    end
    chk("budget7 errs == popcount", errs_last, 4'(pop));
    chk("budget7 errs <= 7", (errs_last <= 4'd7), 1);
    // async reset with a held beat, then the first-beat scenario repeats identically
    cycle(1, 1, 0, 8'h5A, 1, 3, 0);
    chk("held before reset", out_valid, 1);
    do_reset();
    cycle(1, 1, 1, 8'h00, 1, 1, 1);
    chk("post-reset data", out_data, 8'h01);
    chk("post-reset mask", out_err_mask, 8'h01);
    chk("post-reset errs", errs_last, 1);
    chk("post-reset lfsr", dut.lfsr_q, 16'hE270);
    // random traffic, mostly well-formed packets with occasional framing violations
    for (int i = 0; i < 600; i++) begin
      logic s, e;
      s = ($urandom_range(0, 5) == 0);
      e = ($urandom_range(0, 4) == 0);
      cycle($urandom_range(0, 3) != 0, s, e, 8'($urandom), $urandom_range(0, 4) != 0,
            3'($urandom), $urandom_range(0, 3) != 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
